// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults, depth helper and read-mode constants for the FIFO family
package sync_fifo_pkg;
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_ADDRWIDTH = 4;
  localparam int MODE_STD = 0;
  localparam int MODE_FWFT = 1;
  function automatic int depth(input int addrwidth);
    return 1 << addrwidth;
  endfunction
endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: dual-port array, synchronous write port, asynchronous read port
module fifo_mem_dp import sync_fifo_pkg::*; #(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DATAWIDTH-1:0] rdata
);
  logic [DATAWIDTH-1:0] mem [depth(ADDRWIDTH)];
  // store the incoming word; contents are deliberately never cleared
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: synchronous FIFO with occupancy, programmable thresholds, error pulses and optional FWFT
module sync_fifo_flags import sync_fifo_pkg::*; #(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = MODE_STD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic                 rd_en,
  output logic [DATAWIDTH-1:0] data_out,
  output logic                 f_empty,
  output logic                 f_full,
  output logic                 f_afull,
  output logic                 f_aempty,
  output logic [ADDRWIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int DEPTH = depth(ADDRWIDTH);
  localparam logic [ADDRWIDTH:0] FULL_CNT = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] AFULL_CNT = (ADDRWIDTH+1)'(AFULL_TH);
  localparam logic [ADDRWIDTH:0] AEMPTY_CNT = (ADDRWIDTH+1)'(AEMPTY_TH);
  logic [ADDRWIDTH:0] w_ptr, r_ptr;
  logic [DATAWIDTH-1:0] rd_data;
  logic wr_ok, rd_ok;
  // flags depend only on registered pointers so they lag operations by one edge
  assign count    = w_ptr - r_ptr;
  assign f_empty  = count == '0;
  assign f_full   = count == FULL_CNT;
  assign f_afull  = count >= AFULL_CNT;
  assign f_aempty = count <= AEMPTY_CNT;
  // write gated by rst so a reset cycle never disturbs memory
  assign wr_ok = rst && wr_en && !f_full;
  assign rd_ok = rst && rd_en && !f_empty;
  fifo_mem_dp #(.DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (w_ptr[ADDRWIDTH-1:0]),
    .wdata (data_in),
    .raddr (r_ptr[ADDRWIDTH-1:0]),
    .rdata (rd_data)
  );
  // pointer advance and one-cycle error pulses for rejected requests
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + 1'b1;
      if (rd_ok) r_ptr <= r_ptr + 1'b1;
      overflow  <= wr_en && f_full;
      underflow <= rd_en && f_empty;
    end
  end
  if (FWFT == MODE_FWFT) begin : g_fwft
    assign data_out = f_empty ? '0 : rd_data;
  end else begin : g_std
    logic [DATAWIDTH-1:0] dout_q;
    // registered read: capture the head word on an accepted read, hold otherwise
    always_ff @(posedge clk) begin
      if (!rst) dout_q <= '0;
      else if (rd_ok) dout_q <= rd_data;
    end
    assign data_out = dout_q;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed scoreboard bench for standard and FWFT builds
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic f_empty, f_full, f_afull, f_aempty, overflow, underflow;
  logic [4:0] count;
  logic wr_en_f = 1'b0, rd_en_f = 1'b0;
  logic [7:0] data_in_f = '0, data_out_f;
  logic f_empty_f, f_full_f, f_afull_f, f_aempty_f, overflow_f, underflow_f;
  logic [4:0] count_f;
  int checks = 0, failures = 0;
  int mcnt = 0;
  logic [7:0] q[$];
  logic [7:0] exp_dout = '0;
  logic exp_ovf = 1'b0, exp_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .f_empty(f_empty), .f_full(f_full), .f_afull(f_afull),
    .f_aempty(f_aempty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en_f), .data_in(data_in_f), .rd_en(rd_en_f),
    .data_out(data_out_f), .f_empty(f_empty_f), .f_full(f_full_f), .f_afull(f_afull_f),
    .f_aempty(f_aempty_f), .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mcnt));
    chk({tag, ".f_empty"}, 32'(f_empty), 32'(mcnt == 0));
    chk({tag, ".f_full"}, 32'(f_full), 32'(mcnt == 16));
    chk({tag, ".f_afull"}, 32'(f_afull), 32'(mcnt >= 12));
    chk({tag, ".f_aempty"}, 32'(f_aempty), 32'(mcnt <= 4));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
    chk({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
  endtask

  task automatic cyc(input string tag, input logic w, input logic r, input logic [7:0] d);
    logic wa, ra;
    wr_en = w; rd_en = r; data_in = d;
    wa = w && mcnt != 16;
    ra = r && mcnt != 0;
    exp_ovf = w && !wa;
    exp_udf = r && !ra;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    mcnt = mcnt + int'(wa) - int'(ra);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk_all(tag);
  endtask

  task automatic rst_cyc(input string tag, input logic w, input logic r);
    rst = 1'b0; wr_en = w; rd_en = r; data_in = 8'hEE;
    q.delete(); mcnt = 0; exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    rst_cyc("reset", 1'b0, 1'b0);
    chk("fw.reset.empty", 32'(f_empty_f), 32'd1);
    chk("fw.reset.dout", 32'(data_out_f), 32'd0);
    for (int i = 1; i <= 16; i++) cyc("fill", 1'b1, 1'b0, 8'(i));
    cyc("overflow", 1'b1, 1'b0, 8'h77);
    cyc("ovf_clear", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 1'b1, 8'h00);
    cyc("underflow", 1'b0, 1'b1, 8'h00);
    cyc("udf_clear", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cyc("pre8", 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) cyc("steady", 1'b1, 1'b1, 8'(8'h80 + i));
    for (int i = 0; i < 8; i++) cyc("refill", 1'b1, 1'b0, 8'(8'hC0 + i));
    cyc("full_both", 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 15; i++) cyc("empty_out", 1'b0, 1'b1, 8'h00);
    cyc("empty_both", 1'b1, 1'b1, 8'h66);
    for (int i = 0; i < 8; i++) cyc("to9", 1'b1, 1'b0, 8'(8'hD0 + i));
    chk("count9", 32'(count), 32'd9);
    rst_cyc("midreset", 1'b1, 1'b0);
    cyc("post_reset_idle", 1'b0, 1'b0, 8'h00);
    wr_en_f = 1'b1; data_in_f = 8'hA5;
    @(posedge clk); #1;
    wr_en_f = 1'b0;
    chk("fw.show.dout", 32'(data_out_f), 32'hA5);
    chk("fw.show.empty", 32'(f_empty_f), 32'd0);
    chk("fw.show.count", 32'(count_f), 32'd1);
    @(posedge clk); #1;
    chk("fw.hold.dout", 32'(data_out_f), 32'hA5);
    rd_en_f = 1'b1;
    @(posedge clk); #1;
    rd_en_f = 1'b0;
    chk("fw.pop.empty", 32'(f_empty_f), 32'd1);
    chk("fw.pop.dout", 32'(data_out_f), 32'd0);
    wr_en_f = 1'b1; data_in_f = 8'h11;
    @(posedge clk); #1;
    data_in_f = 8'h22;
    @(posedge clk); #1;
    wr_en_f = 1'b0; rd_en_f = 1'b1;
    chk("fw.two.dout", 32'(data_out_f), 32'h11);
    @(posedge clk); #1;
    rd_en_f = 1'b0;
    chk("fw.next.dout", 32'(data_out_f), 32'h22);
    chk("fw.next.count", 32'(count_f), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
